// File: rtl/delay_sequence_driver_pkg.sv
// ============================================================================
// Module  : delay_sequence_driver_pkg
// Purpose : Shared state encoding and default widths for delay_sequence_driver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package delay_sequence_driver_pkg;

    localparam int DEF_CNT_W   = 4;
    localparam int DEF_BURST_W = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRIVE_A = 3'd1,
        WAIT    = 3'd2,
        DRIVE_B = 3'd3,
        DONE    = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/delay_down_counter.sv
// ============================================================================
// Module  : delay_down_counter
// Purpose : Loadable down counter that saturates at zero and flags a value of one.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         enable,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] value,
    output logic         is_one
);

    logic [W-1:0] r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= load_value;
        end else if (enable && (r_value != '0)) begin
            r_value <= r_value - 1'b1;
        end
    end

    assign value  = r_value;
    assign is_one = (r_value == W'(1));

endmodule

`default_nettype wire

// File: rtl/delay_sequence_driver.sv
// ============================================================================
// Module  : delay_sequence_driver
// Purpose : Drives bursts of "a, then b N cycles later" pulse pairs.
//           Define DELAY_SEQUENCE_DRIVER_SVA_EN to embed assertions and covers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_sequence_driver
    import delay_sequence_driver_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   delay_i,
    input  logic [BURST_W-1:0] count_i,
    output logic               a_o,
    output logic               b_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    state_e             r_state;
    state_e             w_next;
    logic [CNT_W-1:0]   r_delay;
    logic [BURST_W-1:0] r_remaining;
    logic [CNT_W-1:0]   w_cnt_value;
    logic               w_cnt_is_one;
    logic               w_start_ok;
    logic               w_start_bad;

    assign w_start_ok  = start_i && (delay_i != '0);
    assign w_start_bad = start_i && (delay_i == '0);

    delay_down_counter #(
        .W (CNT_W)
    ) u_delay_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (r_state == DRIVE_A),
        .enable     (r_state == WAIT),
        .load_value (r_delay - 1'b1),
        .value      (w_cnt_value),
        .is_one     (w_cnt_is_one)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_next = DRIVE_A;
            DRIVE_A: w_next = (r_delay == CNT_W'(1)) ? DRIVE_B : WAIT;
            // A zero count in WAIT cannot occur, but leaving on it rules out a lock-up.
            WAIT:    if (w_cnt_is_one || (w_cnt_value == '0)) w_next = DRIVE_B;
            DRIVE_B: w_next = (r_remaining != '0) ? DRIVE_A : DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_delay     <= '0;
            r_remaining <= '0;
            a_o         <= 1'b0;
            b_o         <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && w_start_ok) begin
                r_delay     <= delay_i;
                r_remaining <= count_i;
            end else if ((r_state == DRIVE_B) && (r_remaining != '0)) begin
                r_remaining <= r_remaining - 1'b1;
            end
            // Outputs are decoded from the next state so they align with it.
            a_o    <= (w_next == DRIVE_A);
            b_o    <= (w_next == DRIVE_B);
            busy_o <= (w_next != IDLE);
            done_o <= (w_next == DONE);
            err_o  <= (r_state == IDLE) && w_start_bad;
        end
    end

`ifdef DELAY_SEQUENCE_DRIVER_SVA_EN
    generate
        for (genvar d = 1; d < (2 ** CNT_W); d++) begin : g_a_to_b
            a_then_b: assert property (@(posedge clk) disable iff (!rst_n)
                (a_o && (r_delay == CNT_W'(d))) |-> ##d b_o);
        end
    endgenerate

    no_ab_overlap: assert property (@(posedge clk) disable iff (!rst_n) !(a_o && b_o));
    pulses_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({a_o, b_o, done_o, err_o}));
    idle_after_done: assert property (@(posedge clk) disable iff (!rst_n) done_o |=> !busy_o);

    cov_delay1: cover property (@(posedge clk) disable iff (!rst_n) a_o && (r_delay == CNT_W'(1)));
    cov_delay3: cover property (@(posedge clk) disable iff (!rst_n) a_o && (r_delay == CNT_W'(3)));
    cov_max_burst: cover property (@(posedge clk) disable iff (!rst_n)
        (a_o && (r_remaining == '1)) ##[1:$] done_o);
`endif

endmodule

`default_nettype wire

// File: tb/tb_delay_sequence_driver.sv
// ============================================================================
// Module  : tb_delay_sequence_driver
// Purpose : Directed scoreboard bench for delay_sequence_driver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_delay_sequence_driver;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_i;
    logic [3:0] delay_i;
    logic [2:0] count_i;
    logic       a_o, b_o, busy_o, done_o, err_o;

    always #5 clk = ~clk;

    delay_sequence_driver dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .delay_i (delay_i),
        .count_i (count_i),
        .a_o     (a_o),
        .b_o     (b_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .err_o   (err_o)
    );

    // Expected output vectors, one per cycle: {a, b, busy, done, err}.
    logic [4:0] exp_q[$];
    int passed = 0;
    int total  = 0;
    int busy_cnt, done_cnt, a_cnt, b_cnt;

    function automatic logic [4:0] obs();
        return {a_o, b_o, busy_o, done_o, err_o};
    endfunction

    task automatic check(input string tag, input logic [4:0] o, input logic [4:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s observed=%b expected=%b (a,b,busy,done,err)", tag, o, e);
    endtask

    task automatic check_int(input string tag, input int o, input int e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    endtask

    // Reference trace: a, then delay-1 busy cycles, then b, per sequence; then done.
    task automatic push_burst(input int d, input int c);
        for (int s = 0; s <= c; s++) begin
            exp_q.push_back(5'b10100);
            for (int i = 1; i < d; i++) exp_q.push_back(5'b00100);
            exp_q.push_back(5'b01100);
        end
        exp_q.push_back(5'b00110);
    endtask

    task automatic step(input string tag);
        logic [4:0] e;
        @(negedge clk);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 5'b00000;
        busy_cnt += int'(busy_o);
        done_cnt += int'(done_o);
        a_cnt    += int'(a_o);
        b_cnt    += int'(b_o);
        check(tag, obs(), e);
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() != 0) step(tag);
        step({tag, "_idle"});
    endtask

    task automatic clear_counts();
        busy_cnt = 0; done_cnt = 0; a_cnt = 0; b_cnt = 0;
    endtask

    initial begin
        start_i = 1'b0;
        delay_i = '0;
        count_i = '0;
        clear_counts();

        // Reset state
        #1 rst_n = 1'b0;
        #1 check("reset_async", obs(), 5'b00000);
        @(negedge clk);
        check("reset_held", obs(), 5'b00000);
        rst_n = 1'b1;
        step("post_reset_idle");

        // 1: delay 3, single sequence
        clear_counts();
        start_i = 1'b1; delay_i = 4'd3; count_i = 3'd0;
        push_burst(3, 0);
        step("t1");
        start_i = 1'b0;
        drain("t1");
        check_int("t1_busy_cycles", busy_cnt, 5);

        // 2: delay 1, three sequences back to back
        clear_counts();
        start_i = 1'b1; delay_i = 4'd1; count_i = 3'd2;
        push_burst(1, 2);
        step("t2");
        start_i = 1'b0;
        drain("t2");
        check_int("t2_a_pulses", a_cnt, 3);
        check_int("t2_b_pulses", b_cnt, 3);

        // 3: zero delay is rejected
        start_i = 1'b1; delay_i = 4'd0; count_i = 3'd5;
        exp_q.push_back(5'b00001);
        step("t3_err");
        start_i = 1'b0;
        step("t3_idle");
        step("t3_idle2");

        // 4: maximum delay, start and delay changes during WAIT are ignored
        start_i = 1'b1; delay_i = 4'd15; count_i = 3'd0;
        push_burst(15, 0);
        step("t4");
        start_i = 1'b0;
        repeat (3) step("t4");
        start_i = 1'b1; delay_i = 4'd2; count_i = 3'd7;
        repeat (2) step("t4_ignored");
        start_i = 1'b0; delay_i = 4'd0;
        drain("t4");

        // 5: asynchronous reset mid-WAIT abandons the burst
        start_i = 1'b1; delay_i = 4'd5; count_i = 3'd1;
        push_burst(5, 1);
        step("t5");
        start_i = 1'b0;
        repeat (2) step("t5");
        #2 rst_n = 1'b0;
        #1 check("t5_reset_immediate", obs(), 5'b00000);
        exp_q.delete();
        @(negedge clk);
        check("t5_reset_held", obs(), 5'b00000);
        rst_n = 1'b1;
        clear_counts();
        repeat (3) step("t5_no_done");
        check_int("t5_done_pulses", done_cnt, 0);
        start_i = 1'b1; delay_i = 4'd2; count_i = 3'd1;
        push_burst(2, 1);
        step("t5_restart");
        start_i = 1'b0;
        drain("t5_restart");

        // 6: maximum-length burst
        clear_counts();
        start_i = 1'b1; delay_i = 4'd2; count_i = 3'd7;
        push_burst(2, 7);
        step("t6");
        start_i = 1'b0;
        drain("t6");
        check_int("t6_a_pulses", a_cnt, 8);
        check_int("t6_b_pulses", b_cnt, 8);
        check_int("t6_busy_cycles", busy_cnt, 8 * 3 + 1);
        check_int("t6_done_pulses", done_cnt, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
